alu_share_arbiter: RTL

- Shares one combinational ALU32bit instance between two requesters, e.g. an integer issue port and an address-generation port.
- Arbitrates round-robin, registers the operands that drive the ALU, and captures the result a cycle later.
- Returns result, branch flag and an illegal-op flag on a single tagged response channel with backpressure.
- Sits between issue logic and the ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_share_pkg.sv | 69 ++++++
 rtl/alu_share_rr_arbiter2.sv | 22 ++
 rtl/alu_share_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and decode helpers for the two-requester ALU sharing block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Primary opcodes understood by the ALU
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_H12   = 6'h12;  // ALU-specific immediate op
    localparam logic [5:0] OP_H13   = 6'h13;  // ALU-specific immediate op
    localparam logic [5:0] OP_H15   = 6'h15;  // ALU-specific immediate op
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;

    // R-type funct codes understood by the ALU
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic alu_op_legal(input logic [5:0] opcode, input logic [5:0] funct);
        logic legal;
        legal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_H12, OP_H13, OP_H15, OP_LW, OP_LBU, OP_LHU,
                OP_SB, OP_SH, OP_SW, OP_LL:            legal = 1'b1;
                default:                               legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

    function automatic logic alu_op_is_branch(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/alu_share_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins, on contention the one not granted last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant_id
);

    // Pick the winner from the two valids and the previous grant
    always_comb begin
        grant_vld = valid0 | valid1;
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters; registered operands, result captured a cycle later.
// Latency: accept at edge N, rsp_valid from edge N+1; at least 3 cycles per operation.
// Backpressure: one operation in flight; no request is accepted until the response is taken.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_instr,
    input  logic [31:0]      req0_rs,
    input  logic [31:0]      req0_rt,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_instr,
    input  logic [31:0]      req1_rs,
    input  logic [31:0]      req1_rt,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_branch,
    output logic             rsp_illegal,
    output logic [5:0]       alu_opcode,
    output logic [5:0]       alu_funct,
    output logic [4:0]       alu_shamt,
    output logic [15:0]      alu_immediate,
    output logic [31:0]      alu_rs,
    output logic [31:0]      alu_rt,
    input  logic [31:0]      alu_result,
    input  logic             alu_sig_branch,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             grant_vld;
    logic             grant_id;
    logic             last_grant;
    logic             accept;
    logic             illegal_q;
    logic [31:0]      win_instr;
    logic [31:0]      win_rs;
    logic [31:0]      win_rt;
    logic [TAG_W-1:0] win_tag;
    logic             unused_instr_bits;

    // Register-number fields are resolved by the issue logic; the ALU never sees them
    assign unused_instr_bits = ^{req0_instr[25:16], req1_instr[25:16]};

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    // Route the granted requester's operands toward the ALU operand registers
    always_comb begin
        win_instr = req0_instr;
        win_rs    = req0_rs;
        win_rt    = req0_rt;
        win_tag   = req0_tag;
        if (grant_id) begin
            win_instr = req1_instr;
            win_rs    = req1_rs;
            win_rt    = req1_rt;
            win_tag   = req1_tag;
        end
    end

    // Next state and handshake: only IDLE grants, only to the arbiter's winner
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // State register; reset drops any in-flight operation on the floor
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's operands, tag and decode; they hold until the next acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_opcode    <= '0;
            alu_funct     <= '0;
            alu_shamt     <= '0;
            alu_immediate <= '0;
            alu_rs        <= '0;
            alu_rt        <= '0;
            rsp_id        <= 1'b0;
            rsp_tag       <= '0;
            last_grant    <= 1'b1;
            illegal_q     <= 1'b0;
        end else if (accept) begin
            alu_opcode    <= win_instr[31:26];
            alu_funct     <= win_instr[5:0];
            alu_shamt     <= win_instr[10:6];
            alu_immediate <= win_instr[15:0];
            alu_rs        <= win_rs;
            alu_rt        <= win_rt;
            rsp_id        <= grant_id;
            rsp_tag       <= win_tag;
            last_grant    <= grant_id;
            illegal_q     <= ~alu_op_legal(win_instr[31:26], win_instr[5:0]);
        end
    end

    // Sample the ALU at the end of EXEC; the stale branch flag is masked for non-branches
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_branch  <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_valid   <= 1'b1;
            rsp_illegal <= illegal_q;
            rsp_result  <= illegal_q ? 32'd0 : alu_result;
            rsp_branch  <= ~illegal_q & alu_sig_branch & alu_op_is_branch(alu_opcode);
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule
